instruction_fetch_unit: RTL and testbench

Fetch stage for the RISC-V core. It owns the PC, issues word-aligned requests to instruction memory over a valid/ready request channel, and receives in-order responses. Fetched instructions, paired with their PC, are buffered in a small FIFO and handed to decode, whose immediate generator consumes inst_out. Taken branches and jumps from execute redirect the PC and flush everything in flight.

---
 rtl/riscv_pkg.sv | 11 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 95 +++++++++
 tb/tb_instruction_fetch_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions used by the fetch stage.
package riscv_pkg;
  localparam int              XLEN             = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_NOP         = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO with occupancy count and synchronous clear; reads return zero while empty.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear_i,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int          AW   = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != FULL);
  assign do_pop  = pop_i && (count_q != '0);

  // NOTE: storage has no reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AW+1)'(1);
    end
  end

  assign rdata_o = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues credit-limited imem requests and buffers {inst, pc} for decode.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_out,
  output logic [XLEN-1:0] inst_pc
);
  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d, flight_pc;
  logic [CW-1:0]     outstanding, fifo_count, drop_q, drop_d;
  logic [2*XLEN-1:0] fifo_rdata;
  logic              req_fire, rsp_fire, inst_fire, keep_rsp;

  // Outstanding requests plus buffered instructions never exceed DEPTH, so the FIFO cannot overflow.
  assign imem_req_valid = !reset && !redirect_valid &&
                          (({1'b0, outstanding} + {1'b0, fifo_count}) < CREDITS);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (outstanding != '0);
  assign keep_rsp       = rsp_fire && (state_q == RUN) && !redirect_valid;
  assign inst_valid     = (fifo_count != '0);
  assign inst_fire      = inst_valid && inst_ready;
  assign inst_out       = fifo_rdata[2*XLEN-1:XLEN];
  assign inst_pc        = fifo_rdata[XLEN-1:0];

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = redirect_pc & ~XLEN'(3);
      drop_d = outstanding - CW'(rsp_fire);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      if (rsp_fire && (state_q == DRAIN)) drop_d = drop_q - CW'(1);
    end
    state_d = (drop_d != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      drop_q  <= '0;
      state_q <= RUN;
    end else begin
      pc_q    <= pc_d;
      drop_q  <= drop_d;
      state_q <= state_d;
    end
  end

  fetch_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (redirect_valid),
    .push_i  (keep_rsp),
    .wdata_i ({imem_rsp_data, flight_pc}),
    .pop_i   (inst_fire),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  // Addresses of requests still awaiting a response; its occupancy is the outstanding count.
  fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_flight_q (
    .clk     (clk),
    .reset   (reset),
    .clear_i (1'b0),
    .push_i  (req_fire),
    .wdata_i (pc_q),
    .pop_i   (rsp_fire),
    .rdata_o (flight_pc),
    .count_o (outstanding)
  );

  a_rsp_has_request: assert property (
    @(posedge clk) disable iff (reset) imem_rsp_valid |-> (outstanding != '0)
  );
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with an in-order latency memory model.
module tb_instruction_fetch_unit;
  import riscv_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk            = 1'b0;
  logic        reset          = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc    = '0;
  logic        inst_valid;
  logic        inst_ready     = 1'b0;
  logic [31:0] inst_out, inst_pc;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_out       (inst_out),
    .inst_pc        (inst_pc)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } mem_req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc; } exp_t;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  logic [31:0] addr_log[$];
  logic [31:0] deliv_pc[$];
  int          checks = 0;
  int          errors = 0;
  int          cycle = 0;
  int          lat = 1;
  int          fifo_cnt = 0;
  int          first_acc = -1;
  int          first_val = -1;
  logic [31:0] pc_model = RST_PC;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %08h, expected %08h (cycle %0d)", tag, got, want, cycle);
    end
  endtask

  function automatic logic [31:0] addr_at(input int idx);
    return (idx < addr_log.size()) ? addr_log[idx] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] deliv_at(input int idx);
    return (idx < deliv_pc.size()) ? deliv_pc[idx] : 32'hxxxx_xxxx;
  endfunction

  task automatic model_reset();
    mem_q.delete();
    exp_q.delete();
    fifo_cnt  = 0;
    pc_model  = RST_PC;
    first_acc = -1;
    first_val = -1;
  endtask

  // Reset is raised mid-cycle and outputs are checked before any clock edge.
  task automatic apply_reset();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0; inst_ready = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_req_valid",  32'(imem_req_valid), 32'd0);
    check("rst_req_addr",   imem_req_addr,       RST_PC);
    check("rst_inst_valid", 32'(inst_valid),     32'd0);
    check("rst_inst_out",   inst_out,            32'd0);
    check("rst_inst_pc",    inst_pc,             32'd0);
    @(posedge clk);
    #2 reset = 1'b0;
    model_reset();
  endtask

  task automatic step(input bit redir, input logic [31:0] rpc, input bit irdy, input bit qrdy);
    mem_req_t r;
    exp_t     e;
    bit       exp_req;
    int       due;
    @(posedge clk);
    #1;
    cycle++;
    redirect_valid = redir;
    redirect_pc    = rpc;
    inst_ready     = irdy;
    imem_req_ready = qrdy;
    if (mem_q.size() != 0 && mem_q[0].due <= cycle) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    @(negedge clk);
    exp_req = !redir && ((mem_q.size() + fifo_cnt) < DEPTH);
    check("req_valid",  32'(imem_req_valid), 32'(exp_req));
    check("req_addr",   imem_req_addr,       pc_model);
    check("inst_valid", 32'(inst_valid),     32'(fifo_cnt > 0));
    if (fifo_cnt > 0 && exp_q.size() != 0) begin
      check("inst_out", inst_out, exp_q[0].inst);
      check("inst_pc",  inst_pc,  exp_q[0].pc);
    end
    if (first_val < 0 && inst_valid) first_val = cycle;
    if (fifo_cnt > 0 && irdy) begin
      deliv_pc.push_back(inst_pc);
      e = exp_q.pop_front();
      fifo_cnt--;
    end
    if (imem_rsp_valid) begin
      r = mem_q.pop_front();
      if (!r.stale && !redir) fifo_cnt++;
    end
    if (imem_req_valid && qrdy) begin
      if (first_acc < 0) first_acc = cycle;
      addr_log.push_back(imem_req_addr);
      due = cycle + lat;
      if (mem_q.size() != 0 && due < mem_q[$].due) due = mem_q[$].due;
      r.addr = imem_req_addr; r.due = due; r.stale = 1'b0;
      mem_q.push_back(r);
      e.inst = mem_data(pc_model); e.pc = pc_model;
      exp_q.push_back(e);
      pc_model = pc_model + 32'd4;
    end
    if (redir) begin
      exp_q.delete();
      fifo_cnt = 0;
      foreach (mem_q[i]) mem_q[i].stale = 1'b1;
      pc_model = rpc & 32'hFFFF_FFFC;
    end
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    int mark;
    bit found;

    // Reset, latency 1, decode always ready.
    apply_reset();
    lat = 1;
    for (int i = 0; i < 12; i++) step(0, '0, 1, 1);
    check("first_valid_latency", 32'(first_val - first_acc), 32'd2);
    check("addr0", addr_at(0), 32'h100);
    check("addr1", addr_at(1), 32'h104);
    check("addr2", addr_at(2), 32'h108);
    check("deliv0", deliv_at(0), 32'h100);
    check("deliv1", deliv_at(1), 32'h104);
    check("deliv2", deliv_at(2), 32'h108);

    // Decode stalled for 10 cycles straight out of reset.
    apply_reset();
    mark = addr_log.size();
    for (int i = 0; i < 10; i++) step(0, '0, 0, 1);
    check("stall_req_count_ok", 32'(addr_log.size() - mark <= DEPTH), 32'd1);
    check("stall_hold_pc",   inst_pc,  RST_PC);
    check("stall_hold_inst", inst_out, mem_data(RST_PC));
    mark = deliv_pc.size();
    for (int i = 0; i < 10; i++) step(0, '0, 1, 1);
    check("resume0", deliv_at(mark),     RST_PC);
    check("resume1", deliv_at(mark + 1), RST_PC + 32'd4);
    check("resume2", deliv_at(mark + 2), RST_PC + 32'd8);

    // Latency 3, redirect with two requests outstanding.
    lat = 3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, '0, 1, 1);
      if (mem_q.size() == 2) found = 1'b1;
    end
    check("lat3_two_outstanding", 32'(mem_q.size()), 32'd2);
    step(1, 32'h0000_0203, 1, 1);
    mark = deliv_pc.size();
    for (int i = 0; i < 20; i++) step(0, '0, 1, 1);
    check("redir_first_pc",  deliv_at(mark),     32'h200);
    check("redir_second_pc", deliv_at(mark + 1), 32'h204);

    // Redirect coinciding with an arriving response and a decode handshake.
    lat = 1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(0, '0, 1, 1);
      if (mem_q.size() != 0 && mem_q[0].due <= cycle + 1 && fifo_cnt > 0) found = 1'b1;
    end
    check("coincide_found", 32'(found), 32'd1);
    step(1, 32'h0000_0400, 1, 1);
    mark = deliv_pc.size();
    for (int i = 0; i < 10; i++) step(0, '0, 1, 1);
    check("coincide_next_pc", deliv_at(mark), 32'h400);

    // PC wrap at the top of the address space.
    step(1, 32'hFFFF_FFF8, 1, 1);
    mark = addr_log.size();
    for (int i = 0; i < 12; i++) step(0, '0, 1, 1);
    check("wrap0", addr_at(mark),     32'hFFFF_FFF8);
    check("wrap1", addr_at(mark + 1), 32'hFFFF_FFFC);
    check("wrap2", addr_at(mark + 2), 32'h0000_0000);

    // Random backpressure and redirects.
    lat = 2;
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 1);

    // Reset mid-stream, fetch restarts at the reset PC.
    apply_reset();
    mark = addr_log.size();
    for (int i = 0; i < 8; i++) step(0, '0, 1, 1);
    check("restart_addr", addr_at(mark), RST_PC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
